// File: rtl/tz_stream.sv
// Serial LSB-first word receiver that reports the trailing-zero count of each
// completed word through a one-entry output buffer.
module tz_stream #(
   parameter int DATA_WIDTH = 32,
   localparam int CW = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [CW-1:0]         dout,
   output logic [DATA_WIDTH-1:0] dout_word,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [IW-1:0]         idx;
   logic [CW-1:0]         cnt;
   logic                  seen_one;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] acc_next;
   logic                  accept;
   logic                  last;

   assign dout_valid = (state_q == FULL);
   // Only the final bit of a word has to wait for a full buffer to drain.
   assign din_ready  = !dout_valid || dout_ready || (idx != LAST_IDX);
   assign accept     = din_valid && din_ready;
   assign last       = accept && (idx == LAST_IDX);

   always_comb begin
      acc_next      = acc;
      acc_next[idx] = din;
   end

   always_comb begin
      state_d = state_q;
      if (last)
         state_d = FULL;
      else if ((state_q == FULL) && dout_ready)
         state_d = EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         cnt       <= '0;
         seen_one  <= 1'b0;
         acc       <= '0;
         dout      <= '0;
         dout_word <= '0;
      end else if (accept) begin
         if (last) begin
            dout      <= (seen_one || din) ? cnt : cnt + 1'b1;
            dout_word <= acc_next;
            idx       <= '0;
            cnt       <= '0;
            seen_one  <= 1'b0;
            acc       <= '0;
         end else begin
            acc <= acc_next;
            idx <= idx + 1'b1;
            if (!seen_one && !din)
               cnt <= cnt + 1'b1;
            if (din)
               seen_one <= 1'b1;
         end
      end
   end

endmodule
